riscv_dmem_arbiter: RTL

RISCV_DMEM_ARBITER -- requirements
Module: riscv_dmem_arbiter

---
 rtl/riscv_dmem_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/riscv_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// riscv_dmem_arbiter
//
// Two-port round-robin arbiter in front of a single-ported data memory.
// Port 0 is the CPU memory stage, port 1 is the DMA/debug master. A lone
// request is accepted in the cycle it is raised; when both ports request,
// the port that did not win the last completed handshake is granted.
// The memory has one cycle of read latency, so every handshake produces a
// one-cycle response on the owning port exactly one cycle later. A grant
// and the previous grant's response can occur in the same cycle, so the
// arbiter sustains one transaction per cycle.
//
// Requests whose byte address lies beyond the memory are still accepted,
// but never reach the memory; they return err=1 with zero data.
//
// Ports
//   i_clk, i_rstn                 clock, asynchronous active-low reset
//   i_reqN_valid/we/addr/wdata/bsel
//                                 request from port N (0 = CPU, 1 = DMA)
//   o_reqN_ready                  request on port N accepted this cycle
//   o_rspN_valid/rdata/err        one-cycle response to port N
//   o_stall_cpu                   CPU request pending but not accepted
//   o_mem_wr_en/byte_sel/addr/wdata
//                                 data-memory command (word address)
//   i_mem_rdata                   data-memory read data, one cycle latency
// ---------------------------------------------------------------------------
module riscv_dmem_arbiter #(
    parameter int XLEN          = 32,
    parameter int DMEM_ADDR_BIT = 12
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,

    input  logic                     i_req0_valid,
    input  logic                     i_req0_we,
    input  logic [XLEN-1:0]          i_req0_addr,
    input  logic [XLEN-1:0]          i_req0_wdata,
    input  logic [3:0]               i_req0_bsel,
    output logic                     o_req0_ready,
    output logic                     o_rsp0_valid,
    output logic [XLEN-1:0]          o_rsp0_rdata,
    output logic                     o_rsp0_err,

    input  logic                     i_req1_valid,
    input  logic                     i_req1_we,
    input  logic [XLEN-1:0]          i_req1_addr,
    input  logic [XLEN-1:0]          i_req1_wdata,
    input  logic [3:0]               i_req1_bsel,
    output logic                     o_req1_ready,
    output logic                     o_rsp1_valid,
    output logic [XLEN-1:0]          o_rsp1_rdata,
    output logic                     o_rsp1_err,

    output logic                     o_stall_cpu,

    output logic                     o_mem_wr_en,
    output logic [3:0]               o_mem_byte_sel,
    output logic [DMEM_ADDR_BIT-3:0] o_mem_addr,
    output logic [XLEN-1:0]          o_mem_wdata,
    input  logic [XLEN-1:0]          i_mem_rdata
);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } portId_t;

    // Arbitration history and the response owed for last cycle's handshake.
    portId_t lastGrant;
    logic    pendValid;
    portId_t pendOwner;
    logic    pendErr;
    logic    pendRead;

    logic            grant0;
    logic            grant1;
    logic            anyGrant;
    logic            selWe;
    logic [XLEN-1:0] selAddr;
    logic [XLEN-1:0] selWdata;
    logic [3:0]      selBsel;
    logic            selOutOfRange;
    logic            outOfRange0;
    logic            outOfRange1;
    logic [XLEN-1:0] rspData;

    // The word offset never selects lanes; byte enables do that.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{i_req0_addr[1:0], i_req1_addr[1:0]};

    // Any set bit at or above DMEM_ADDR_BIT puts the address past the memory.
    assign outOfRange0 = |i_req0_addr[XLEN-1:DMEM_ADDR_BIT];
    assign outOfRange1 = |i_req1_addr[XLEN-1:DMEM_ADDR_BIT];

    // Grant is purely combinational so a lone request waits zero cycles.
    // Ready is held low while reset is asserted so every output is quiet.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (i_rstn) begin
            if (i_req0_valid && (!i_req1_valid || lastGrant == PORT1)) begin
                grant0 = 1'b1;
            end else if (i_req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign anyGrant     = grant0 | grant1;
    assign o_req0_ready = grant0;
    assign o_req1_ready = grant1;
    assign o_stall_cpu  = i_rstn & i_req0_valid & ~grant0;

    // Payload of whichever port holds the grant.
    always_comb begin
        selWe         = 1'b0;
        selAddr       = '0;
        selWdata      = '0;
        selBsel       = '0;
        selOutOfRange = 1'b0;
        if (grant0) begin
            selWe         = i_req0_we;
            selAddr       = i_req0_addr;
            selWdata      = i_req0_wdata;
            selBsel       = i_req0_bsel;
            selOutOfRange = outOfRange0;
        end else if (grant1) begin
            selWe         = i_req1_we;
            selAddr       = i_req1_addr;
            selWdata      = i_req1_wdata;
            selBsel       = i_req1_bsel;
            selOutOfRange = outOfRange1;
        end
    end

    // Out-of-range requests are swallowed here: the memory sees an idle cycle.
    always_comb begin
        o_mem_wr_en    = 1'b0;
        o_mem_byte_sel = '0;
        o_mem_addr     = '0;
        o_mem_wdata    = '0;
        if (anyGrant && !selOutOfRange) begin
            o_mem_wr_en    = selWe;
            o_mem_byte_sel = selBsel;
            o_mem_addr     = selAddr[DMEM_ADDR_BIT-1:2];
            o_mem_wdata    = selWdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            lastGrant <= PORT1;
            pendValid <= 1'b0;
            pendOwner <= PORT0;
            pendErr   <= 1'b0;
            pendRead  <= 1'b0;
        end else begin
            pendValid <= anyGrant;
            if (anyGrant) begin
                lastGrant <= grant1 ? PORT1 : PORT0;
                pendOwner <= grant1 ? PORT1 : PORT0;
                pendErr   <= selOutOfRange;
                pendRead  <= ~selWe;
            end
        end
    end

    // Read data is only meaningful for an in-range read; writes and errors
    // return zero regardless of what the memory presents.
    assign rspData = (pendValid && pendRead && !pendErr) ? i_mem_rdata : '0;

    always_comb begin
        o_rsp0_valid = 1'b0;
        o_rsp0_rdata = '0;
        o_rsp0_err   = 1'b0;
        o_rsp1_valid = 1'b0;
        o_rsp1_rdata = '0;
        o_rsp1_err   = 1'b0;
        if (pendValid) begin
            if (pendOwner == PORT0) begin
                o_rsp0_valid = 1'b1;
                o_rsp0_rdata = rspData;
                o_rsp0_err   = pendErr;
            end else begin
                o_rsp1_valid = 1'b1;
                o_rsp1_rdata = rspData;
                o_rsp1_err   = pendErr;
            end
        end
    end

endmodule
